frv_fetch_realign: RTL and testbench
====================================

Name: frv_fetch_realign

Overview:
- Instruction realignment buffer sitting between the fetch memory interface and the decode stage.
- Accepts naturally aligned 32-bit fetch words plus a per-word bus error flag and stores them as halfwords.
- Presents exactly one whole RV32IC instruction (16- or 32-bit, any halfword alignment) per handshake on the d_valid / d_data / d_error interface consumed by decode.
- Handles the misaligned-start case after a control-flow flush, when the target PC has bit 1 set.

Parameters:
- None. Storage depth is fixed at 4 halfword slots.

Ports:
- g_clk  input  1  Core clock. All state updates on the rising edge.
- g_reset  input  1  Synchronous, active-high reset.
- f_flush  input  1  Discard all buffered halfwords; the stream restarts at a new PC.
- f_flush_pc1  input  1  Bit 1 of the new PC. Sampled only when f_flush=1.
- f_in_valid  input  1  Fetch word valid.
- f_in_ready  output  1  Buffer can accept a fetch word this cycle.
- f_in_data  input  32  Aligned fetch word. Bits [15:0] are the lower-address halfword.
- f_in_error  input  1  Bus/access error for this fetch word.
- d_valid  output  1  A complete instruction is presented.
- d_data  output  32  Instruction word. Bits [31:16] are zero for a 16-bit instruction.
- d_error  output  1  The presented instruction touches a halfword fetched with an error.
- d_ready  input  1  Decode/pipeline accepts the presented instruction.

Behaviour:
- **State:**
  - 4 slots, each holding 16 data bits and 1 error bit; slot0 is the oldest.
  - count: 0..4 occupied slots.
  - drop_lo: the next accepted word's lower halfword is discarded.
- **Reset (g_reset=1 at a clock edge):**
  - count=0, drop_lo=0, all slots cleared to zero.
  - Afterwards: d_valid=0, d_data=0, d_error=0, f_in_ready=1.
- **Instruction length:**
  - is32 = (slot0[1:0]==2'b11).
  - need = is32 ? 2 : 1.
- **Output decode:**
  - d_valid = !f_flush && (count>=need || (count>=1 && slot0.err)).
  - A slot0 error presents immediately, without waiting for the second halfword.
  - d_data = is32 ? {slot1, slot0} : {16'b0, slot0}.
  - When is32 and count==1 (error case), the upper half of d_data is zero.
  - d_error = slot0.err || (is32 && count>=2 && slot1.err).
  - d_data and d_error are combinational from state only.
- **Consume:**
  - Fires when d_valid && d_ready.
  - Removes need slots, or 1 slot when is32 && count==1 (error case).
  - Remaining slots shift down.
- **Input acceptance:**
  - f_in_ready = !f_flush && count<=2, derived from registered count only.
  - It has no combinational dependence on d_ready.
  - Push fires when f_in_valid && f_in_ready.
  - Push with drop_lo=0 appends halfwords [15:0] then [31:16], both tagged f_in_error; count += 2.
  - Push with drop_lo=1 appends only [31:16] with f_in_error; count += 1; drop_lo is cleared.
- **Simultaneous consume and push:**
  - Consume is applied first, then appended halfwords land at the post-consume tail.
  - Next count = count − consumed + pushed; never exceeds 4.
- **Latency:**
  - A word accepted at edge N is visible on d_* from cycle N+1. There is no input-to-output bypass.
  - Sustained throughput is one instruction per cycle while the input keeps pace.
- **Flush:**
  - f_flush=1 in a cycle forces d_valid=0 and f_in_ready=0 in that cycle, so no handshake completes.
  - At the next edge: count=0, drop_lo=f_flush_pc1.
  - Flush has priority over consume and push.
  - g_reset has priority over f_flush.
  - Squashing stale in-flight bus responses is the fetch unit's job; every word accepted after a flush belongs to the new stream.
- **Boundary cases:**
  - Full (count=4): f_in_ready=0; decode continues draining.
  - count=3: f_in_ready=0, even when a consume is happening.
  - Empty: d_valid=0.
  - Lone 32-bit low half without error: d_valid stays 0 until the upper half arrives.
  - Back-to-back flushes: the last one wins for drop_lo.
  - Reset mid-instruction: all partial state is lost.

Test Plan:
- Reset: assert g_reset 2 cycles → d_valid=0, d_data=0, d_error=0, f_in_ready=1.
- Aligned 32-bit: push 0x00000013, d_ready=1 → next cycle d_valid=1, d_data=0x00000013, d_error=0; following cycle d_valid=0, count=0.
- Two compressed: push 0x45014501, d_ready held 1 → two consecutive cycles with d_valid=1, d_data=0x00004501; then d_valid=0.
- Misaligned start and split instruction: f_flush=1, f_flush_pc1=1; then push 0x0013ABCD → d_valid=0 (0xABCD dropped, half of 32-bit pending). Push 0x45010000 → d_data=0x00000013 first, then d_data=0x00004501.
- Errors:
  - Push 0x00000013 with f_in_error=1 → d_valid=1, d_error=1.
  - Flush with f_flush_pc1=1, push 0x00130000 with error=0, then 0x00000000 with error=1 → d_data=0x00000013, d_error=1.
- Backpressure and flush: d_ready=0, push 0x45014501 and 0x45014501 → count=4, f_in_ready=0, a third offered word is not accepted. Assert f_flush mid-stream → d_valid=0 that cycle and the next, f_in_ready=1 the cycle after flush.

Source files
------------

// File: rtl/frv_fetch_realign.sv
// Fetch realignment buffer: turns aligned 32-bit fetch words into whole RV32IC
// instructions (16/32-bit, any halfword alignment) for the decode stage.
module frv_fetch_realign (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        f_flush,
  input  logic        f_flush_pc1,
  input  logic        f_in_valid,
  output logic        f_in_ready,
  input  logic [31:0] f_in_data,
  input  logic        f_in_error,
  output logic        d_valid,
  output logic [31:0] d_data,
  output logic        d_error,
  input  logic        d_ready
);

  logic [15:0] slot_data_q [4];
  logic [15:0] slot_data_d [4];
  logic [3:0]  slot_err_q;
  logic [3:0]  slot_err_d;
  logic [2:0]  count_q;
  logic [2:0]  count_d;
  logic        drop_lo_q;
  logic        drop_lo_d;

  logic        is32;
  logic [2:0]  need;
  logic        consume;
  logic        push;
  logic [2:0]  cons_n;
  logic [2:0]  tail;

  always_comb begin
    is32 = (slot_data_q[0][1:0] == 2'b11);
    need = is32 ? 3'd2 : 3'd1;
    // An errored oldest halfword is presented alone so decode can trap early.
    d_valid = !f_flush && ((count_q >= need) || ((count_q >= 3'd1) && slot_err_q[0]));
    if (is32 && (count_q >= 3'd2)) begin
      d_data = {slot_data_q[1], slot_data_q[0]};
    end else begin
      d_data = {16'h0000, slot_data_q[0]};
    end
    d_error    = slot_err_q[0] || (is32 && (count_q >= 3'd2) && slot_err_q[1]);
    f_in_ready = !f_flush && (count_q <= 3'd2);
    consume    = d_valid && d_ready;
    push       = f_in_valid && f_in_ready;
  end

  always_comb begin
    if (consume) begin
      cons_n = (is32 && (count_q >= 3'd2)) ? 3'd2 : 3'd1;
    end else begin
      cons_n = 3'd0;
    end
    tail = count_q - cons_n;

    for (int i = 0; i < 4; i++) begin
      if ((3'(i) + cons_n) <= 3'd3) begin
        slot_data_d[i] = slot_data_q[2'(3'(i) + cons_n)];
        slot_err_d[i]  = slot_err_q[2'(3'(i) + cons_n)];
      end else begin
        slot_data_d[i] = 16'h0000;
        slot_err_d[i]  = 1'b0;
      end
    end

    count_d   = tail;
    drop_lo_d = drop_lo_q;
    // Push is only possible with count<=2, so the tail index never overflows.
    if (push) begin
      if (drop_lo_q) begin
        slot_data_d[tail[1:0]] = f_in_data[31:16];
        slot_err_d[tail[1:0]]  = f_in_error;
        count_d                = tail + 3'd1;
        drop_lo_d              = 1'b0;
      end else begin
        slot_data_d[tail[1:0]]        = f_in_data[15:0];
        slot_err_d[tail[1:0]]         = f_in_error;
        slot_data_d[2'(tail + 3'd1)]  = f_in_data[31:16];
        slot_err_d[2'(tail + 3'd1)]   = f_in_error;
        count_d                       = tail + 3'd2;
      end
    end else begin
      count_d = tail;
    end

    if (f_flush) begin
      count_d   = 3'd0;
      drop_lo_d = f_flush_pc1;
    end else begin
      drop_lo_d = drop_lo_d;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      for (int i = 0; i < 4; i++) begin
        slot_data_q[i] <= 16'h0000;
      end
      slot_err_q <= 4'b0000;
      count_q    <= 3'd0;
      drop_lo_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        slot_data_q[i] <= slot_data_d[i];
      end
      slot_err_q <= slot_err_d;
      count_q    <= count_d;
      drop_lo_q  <= drop_lo_d;
    end
  end

endmodule

// File: tb/tb_frv_fetch_realign.sv
// Self-checking bench for frv_fetch_realign: directed scenarios plus random
// traffic against a halfword-queue reference model.
module tb_frv_fetch_realign;

  logic        g_clk;
  logic        g_reset;
  logic        f_flush;
  logic        f_flush_pc1;
  logic        f_in_valid;
  logic        f_in_ready;
  logic [31:0] f_in_data;
  logic        f_in_error;
  logic        d_valid;
  logic [31:0] d_data;
  logic        d_error;
  logic        d_ready;

  int total;
  int bad;

  logic [16:0] mq[$];
  logic        m_drop;

  logic        obs_valid;
  logic [31:0] obs_data;
  logic        obs_error;
  logic        obs_ready;

  frv_fetch_realign dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .f_flush    (f_flush),
    .f_flush_pc1(f_flush_pc1),
    .f_in_valid (f_in_valid),
    .f_in_ready (f_in_ready),
    .f_in_data  (f_in_data),
    .f_in_error (f_in_error),
    .d_valid    (d_valid),
    .d_data     (d_data),
    .d_error    (d_error),
    .d_ready    (d_ready)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic rst, input logic fl, input logic pc1, input logic iv,
                      input logic [31:0] idat, input logic ierr, input logic dr);
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_data;
    logic        e_err;
    logic        lo32;
    int          sz;
    @(negedge g_clk);
    g_reset = rst; f_flush = fl; f_flush_pc1 = pc1; f_in_valid = iv;
    f_in_data = idat; f_in_error = ierr; d_ready = dr;
    #1;
    sz      = mq.size();
    lo32    = (sz > 0) && (mq[0][1:0] == 2'b11);
    e_valid = !fl && (sz > 0) && ((lo32 ? (sz >= 2) : 1'b1) || mq[0][16]);
    e_ready = !fl && (sz <= 2);
    e_data  = 32'h0;
    e_err   = 1'b0;
    if (sz > 0) begin
      e_data = (lo32 && sz >= 2) ? {mq[1][15:0], mq[0][15:0]} : {16'h0, mq[0][15:0]};
      e_err  = mq[0][16] || (lo32 && sz >= 2 && mq[1][16]);
    end
    obs_valid = d_valid; obs_data = d_data; obs_error = d_error; obs_ready = f_in_ready;
    check("d_valid", {31'h0, d_valid}, {31'h0, e_valid});
    check("f_in_ready", {31'h0, f_in_ready}, {31'h0, e_ready});
    if (e_valid) begin
      check("d_data", d_data, e_data);
      check("d_error", {31'h0, d_error}, {31'h0, e_err});
    end
    @(posedge g_clk);
    if (rst) begin
      mq.delete();
      m_drop = 1'b0;
    end else if (fl) begin
      mq.delete();
      m_drop = pc1;
    end else begin
      if (e_valid && dr) begin
        void'(mq.pop_front());
        if (lo32 && sz >= 2) void'(mq.pop_front());
      end
      if (iv && e_ready) begin
        if (!m_drop) mq.push_back({ierr, idat[15:0]});
        mq.push_back({ierr, idat[31:16]});
        m_drop = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input logic dr);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, dr);
  endtask

  task automatic push(input logic [31:0] w, input logic e, input logic dr);
    step(1'b0, 1'b0, 1'b0, 1'b1, w, e, dr);
  endtask

  task automatic flush(input logic pc1);
    step(1'b0, 1'b1, pc1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0; m_drop = 1'b0;
    g_reset = 1'b1; f_flush = 1'b0; f_flush_pc1 = 1'b0; f_in_valid = 1'b0;
    f_in_data = 32'h0; f_in_error = 1'b0; d_ready = 1'b0;
    @(posedge g_clk);
    @(posedge g_clk);
    #1;
    check("rst_valid", {31'h0, d_valid}, 32'h0);
    check("rst_data", d_data, 32'h0);
    check("rst_error", {31'h0, d_error}, 32'h0);
    check("rst_ready", {31'h0, f_in_ready}, 32'h1);

    // Aligned 32-bit instruction
    push(32'h0000_0013, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("a32_data", obs_data, 32'h0000_0013);
    check("a32_valid", {31'h0, obs_valid}, 32'h1);
    idle(1, 1'b1);
    check("a32_empty", {31'h0, obs_valid}, 32'h0);

    // Two compressed in one word
    push(32'h4501_4501, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("c16_first", obs_data, 32'h0000_4501);
    idle(1, 1'b1);
    check("c16_second", obs_data, 32'h0000_4501);
    idle(1, 1'b1);
    check("c16_empty", {31'h0, obs_valid}, 32'h0);

    // Misaligned start with a split 32-bit instruction
    flush(1'b1);
    push(32'h0013_ABCD, 1'b0, 1'b1);
    push(32'h4501_0000, 1'b0, 1'b1);
    check("split_wait", {31'h0, obs_valid}, 32'h0);
    idle(1, 1'b1);
    check("split_32", obs_data, 32'h0000_0013);
    idle(1, 1'b1);
    check("split_16", obs_data, 32'h0000_4501);
    idle(1, 1'b1);

    // Error tagging
    push(32'h0000_0013, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("err_valid", {31'h0, obs_valid}, 32'h1);
    check("err_flag", {31'h0, obs_error}, 32'h1);
    idle(1, 1'b1);
    flush(1'b1);
    push(32'h0013_0000, 1'b0, 1'b1);
    push(32'h0000_0000, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("err_hi_data", obs_data, 32'h0000_0013);
    check("err_hi_flag", {31'h0, obs_error}, 32'h1);
    idle(3, 1'b1);

    // Lone errored low half of a 32-bit instruction presents at once
    flush(1'b1);
    push(32'h0003_0000, 1'b1, 1'b0);
    idle(1, 1'b0);
    check("lone_err_valid", {31'h0, obs_valid}, 32'h1);
    check("lone_err_data", obs_data, 32'h0000_0003);
    idle(2, 1'b1);

    // Backpressure, full buffer, flush mid-stream
    push(32'h4501_4501, 1'b0, 1'b0);
    push(32'h4501_4501, 1'b0, 1'b0);
    push(32'h1111_2222, 1'b0, 1'b0);
    check("full_ready", {31'h0, obs_ready}, 32'h0);
    flush(1'b0);
    check("flush_valid", {31'h0, obs_valid}, 32'h0);
    idle(1, 1'b1);
    check("post_flush_valid", {31'h0, obs_valid}, 32'h0);
    check("post_flush_ready", {31'h0, obs_ready}, 32'h1);

    // Count=3 with a consume still refuses input
    push(32'h0000_4501, 1'b0, 1'b0);
    push(32'h0000_4501, 1'b0, 1'b1);
    idle(1, 1'b1);
    idle(4, 1'b1);

    // Back-to-back flushes: last wins
    flush(1'b1);
    flush(1'b0);
    push(32'h4501_4502, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("bb_flush_data", obs_data, 32'h0000_4502);
    idle(3, 1'b1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] w;
      logic [15:0] h0;
      logic [15:0] h1;
      h0 = 16'($urandom);
      h1 = 16'($urandom);
      if ($urandom_range(0, 2) == 0) h0[1:0] = 2'b11;
      w = {h1, h0};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0, 1'($urandom),
           $urandom_range(0, 9) < 7, w, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
